// File: rtl/memory_arbiter.sv
// Shared-RAM arbiter for CPUS icache/dcache pairs: registered round-robin grant
// with data priority, plus a one-cycle invalidate broadcast after every data write.
package cpu_types_pkg;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
endpackage

module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int CPUS = 2,
  parameter int AW   = 32,
  parameter int DW   = 32
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic [CPUS-1:0]          iREN,
  input  logic [CPUS-1:0][AW-1:0]  iaddr,
  input  logic [CPUS-1:0]          dREN,
  input  logic [CPUS-1:0]          dWEN,
  input  logic [CPUS-1:0][AW-1:0]  daddr,
  input  logic [CPUS-1:0][DW-1:0]  dstore,
  output logic [CPUS-1:0]          iwait,
  output logic [CPUS-1:0]          dwait,
  output logic [CPUS-1:0][DW-1:0]  iload,
  output logic [CPUS-1:0][DW-1:0]  dload,
  output logic [CPUS-1:0]          ccwait,
  output logic [CPUS-1:0]          ccinv,
  output logic [CPUS-1:0][AW-1:0]  ccsnoopaddr,
  input  ramstate_t                ramstate,
  input  logic [DW-1:0]            ramload,
  output logic                     ramREN,
  output logic                     ramWEN,
  output logic [AW-1:0]            ramaddr,
  output logic [DW-1:0]            ramstore
);

  localparam int GW = (CPUS > 1) ? $clog2(CPUS) : 1;

  typedef enum logic [1:0] {IDLE, XFER, INV} state_t;

  state_t        state, state_n;
  logic [GW-1:0] gcpu, gcpu_n;
  logic          gdata, gdata_n;
  logic          gwr, gwr_n;
  logic [GW-1:0] dptr, dptr_n;
  logic [GW-1:0] iptr, iptr_n;
  logic [AW-1:0] invaddr, invaddr_n;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] store_q;

  logic [CPUS-1:0] dreq;
  logic [GW-1:0]   dsel, isel, gnext;
  logic            req_held, complete;
  logic [AW-1:0]   xfer_addr;

  // First requester at or after ptr, scanning upward modulo CPUS.
  function automatic logic [GW-1:0] rr_pick(input logic [CPUS-1:0] req,
                                             input logic [GW-1:0]   ptr);
    logic [GW-1:0] pick;
    int            idx;
    pick = '0;
    for (int i = CPUS - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % CPUS;
      if (req[idx]) pick = GW'(idx);
    end
    return pick;
  endfunction

  always_comb begin
    dreq      = dREN | dWEN;
    dsel      = rr_pick(dreq, dptr);
    isel      = rr_pick(iREN, iptr);
    gnext     = (int'(gcpu) + 1 >= CPUS) ? '0 : GW'(int'(gcpu) + 1);
    req_held  = gdata ? dreq[gcpu] : iREN[gcpu];
    complete  = (state == XFER) && req_held && (ramstate == ACCESS);
    xfer_addr = gdata ? daddr[gcpu] : iaddr[gcpu];
  end

  // State and grant registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= IDLE;
      gcpu    <= '0;
      gdata   <= 1'b0;
      gwr     <= 1'b0;
      dptr    <= '0;
      iptr    <= '0;
      invaddr <= '0;
      addr_q  <= '0;
      store_q <= '0;
    end else begin
      state   <= state_n;
      gcpu    <= gcpu_n;
      gdata   <= gdata_n;
      gwr     <= gwr_n;
      dptr    <= dptr_n;
      iptr    <= iptr_n;
      invaddr <= invaddr_n;
      if (state == XFER) begin
        addr_q  <= xfer_addr;
        store_q <= dstore[gcpu];
      end
    end
  end

  // Next-state and next-grant logic
  always_comb begin
    state_n   = state;
    gcpu_n    = gcpu;
    gdata_n   = gdata;
    gwr_n     = gwr;
    dptr_n    = dptr;
    iptr_n    = iptr;
    invaddr_n = invaddr;
    unique case (state)
      IDLE: begin
        if (|dreq) begin
          gcpu_n  = dsel;
          gdata_n = 1'b1;
          gwr_n   = dWEN[dsel];
          state_n = XFER;
        end else if (|iREN) begin
          gcpu_n  = isel;
          gdata_n = 1'b0;
          gwr_n   = 1'b0;
          state_n = XFER;
        end
      end
      XFER: begin
        if (!req_held) begin
          state_n = IDLE;
        end else if (ramstate == ACCESS) begin
          if (gdata) dptr_n = gnext;
          else       iptr_n = gnext;
          if (gwr) begin
            invaddr_n = daddr[gcpu];
            state_n   = INV;
          end else begin
            state_n = IDLE;
          end
        end else if (ramstate == ERROR) begin
          state_n = IDLE;
        end
      end
      INV:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs; address/store are forwarded live during XFER and held otherwise
  always_comb begin
    iwait    = '1;
    dwait    = '1;
    ccinv    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = addr_q;
    ramstore = store_q;
    if (state == XFER) begin
      ramREN   = ~gwr;
      ramWEN   = gwr;
      ramaddr  = xfer_addr;
      ramstore = dstore[gcpu];
    end
    if (complete) begin
      if (gdata) dwait[gcpu] = 1'b0;
      else       iwait[gcpu] = 1'b0;
    end
    for (int j = 0; j < CPUS; j++) begin
      iload[j]       = ramload;
      dload[j]       = ramload;
      ccsnoopaddr[j] = invaddr;
      if (state == INV && GW'(j) != gcpu) ccinv[j] = 1'b1;
    end
    ccwait = ccinv;
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with CPUS=2: grant order, latency, write
// invalidate, error retry, abort and asynchronous reset.
module tb_memory_arbiter;
  import cpu_types_pkg::*;

  localparam int CPUS = 2;
  localparam int AW   = 32;
  localparam int DW   = 32;

  logic                    CLK = 1'b0;
  logic                    nRST;
  logic [CPUS-1:0]         iREN, dREN, dWEN;
  logic [CPUS-1:0][AW-1:0] iaddr, daddr;
  logic [CPUS-1:0][DW-1:0] dstore;
  logic [CPUS-1:0]         iwait, dwait, ccwait, ccinv;
  logic [CPUS-1:0][DW-1:0] iload, dload;
  logic [CPUS-1:0][AW-1:0] ccsnoopaddr;
  ramstate_t               ramstate;
  logic [DW-1:0]           ramload;
  logic                    ramREN, ramWEN;
  logic [AW-1:0]           ramaddr;
  logic [DW-1:0]           ramstore;

  int tests = 0;
  int fails = 0;

  memory_arbiter #(.CPUS(CPUS), .AW(AW), .DW(DW)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
    .ramstate(ramstate), .ramload(ramload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore)
  );

  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    nRST = 1'b0; iREN = '0; dREN = '0; dWEN = '0;
    iaddr = '0; daddr = '0; dstore = '0;
    ramstate = FREE; ramload = '0;
    #3;
    check("rst_ramREN", ramREN, 0);
    check("rst_ramWEN", ramWEN, 0);
    check("rst_ramaddr", ramaddr, 0);
    check("rst_iwait", iwait, 2'b11);
    check("rst_dwait", dwait, 2'b11);
    check("rst_ccinv", ccinv, 0);
    #4 nRST = 1'b1;

    // Single instruction read, ACCESS on the second XFER cycle
    tick();
    iREN = 2'b01; iaddr[0] = 32'h100;
    #1 check("t1_idle_ren", ramREN, 0);
    tick();
    check("t1_x1_ren", ramREN, 1);
    check("t1_x1_addr", ramaddr, 32'h100);
    check("t1_x1_iwait", iwait, 2'b11);
    tick();
    ramstate = ACCESS; ramload = 32'h12345678;
    #1 check("t1_x2_iwait", iwait, 2'b10);
    check("t1_x2_iload", iload[0], 32'h12345678);
    check("t1_x2_ren", ramREN, 1);
    tick();
    ramstate = FREE; iREN = '0;
    #1 check("t1_post_ren", ramREN, 0);
    check("t1_post_iwait", iwait, 2'b11);
    check("t1_post_addr_hold", ramaddr, 32'h100);

    // Data beats instruction; one IDLE cycle between
    iREN = 2'b01; dREN = 2'b10; daddr[1] = 32'h300;
    tick();
    check("t2_d_addr", ramaddr, 32'h300);
    check("t2_d_ren", ramREN, 1);
    ramstate = ACCESS; ramload = 32'hA5A5_0001;
    #1 check("t2_d_dwait", dwait, 2'b01);
    check("t2_d_iwait", iwait, 2'b11);
    check("t2_d_dload", dload[1], 32'hA5A5_0001);
    tick();
    ramstate = FREE; dREN = '0;
    #1 check("t2_gap_ren", ramREN, 0);
    tick();
    check("t2_i_addr", ramaddr, 32'h100);
    ramstate = ACCESS;
    #1 check("t2_i_iwait", iwait, 2'b10);
    tick();
    iREN = '0; ramstate = FREE;

    // Continuous data requests from both CPUs, immediate ACCESS: 0,1,0,1
    dREN = 2'b11; daddr[0] = 32'h400; daddr[1] = 32'h500; ramstate = ACCESS;
    tick();
    check("t3_g0_addr", ramaddr, 32'h400);
    check("t3_g0_dwait", dwait, 2'b10);
    tick();
    check("t3_idle_ren", ramREN, 0);
    tick();
    check("t3_g1_addr", ramaddr, 32'h500);
    check("t3_g1_dwait", dwait, 2'b01);
    tick();
    tick();
    check("t3_g2_addr", ramaddr, 32'h400);
    check("t3_g2_dwait", dwait, 2'b10);
    tick();
    tick();
    check("t3_g3_addr", ramaddr, 32'h500);
    check("t3_g3_dwait", dwait, 2'b01);
    tick();
    dREN = '0; ramstate = FREE;

    // Write from CPU1 followed by a one-cycle invalidate to CPU0
    dWEN = 2'b10; daddr[1] = 32'h2040; dstore[1] = 32'hDEADBEEF;
    tick();
    check("t4_wen", ramWEN, 1);
    check("t4_ren", ramREN, 0);
    check("t4_store", ramstore, 32'hDEADBEEF);
    check("t4_addr", ramaddr, 32'h2040);
    ramstate = ACCESS;
    #1 check("t4_dwait", dwait, 2'b01);
    check("t4_noinv_yet", ccinv, 2'b00);
    tick();
    dWEN = '0; ramstate = FREE;
    #1 check("t4_ccinv", ccinv, 2'b01);
    check("t4_ccwait", ccwait, 2'b01);
    check("t4_snoop0", ccsnoopaddr[0], 32'h2040);
    check("t4_inv_wen", ramWEN, 0);
    check("t4_inv_dwait", dwait, 2'b11);
    tick();
    check("t4_ccinv_off", ccinv, 2'b00);

    // ERROR aborts without ready, then the same request is re-granted
    dREN = 2'b01; daddr[0] = 32'h600;
    tick();
    check("t5_ren", ramREN, 1);
    ramstate = ERROR;
    #1 check("t5_err_dwait", dwait, 2'b11);
    tick();
    ramstate = FREE;
    #1 check("t5_idle_ren", ramREN, 0);
    tick();
    check("t5_retry_addr", ramaddr, 32'h600);
    check("t5_retry_ren", ramREN, 1);
    ramstate = ACCESS;
    #1 check("t5_retry_dwait", dwait, 2'b10);
    tick();
    dREN = '0; ramstate = FREE;

    // Request dropped mid-XFER: no ready, pointer unchanged
    dREN = 2'b01; daddr[0] = 32'h700;
    tick();
    check("t6_addr", ramaddr, 32'h700);
    dREN = 2'b00; ramstate = ACCESS;
    #1 check("t6_abort_dwait", dwait, 2'b11);
    tick();
    ramstate = FREE;
    #1 check("t6_abort_ren", ramREN, 0);
    dREN = 2'b11; daddr[1] = 32'h800;
    tick();
    check("t6_ptr_kept", ramaddr, 32'h800);

    // Asynchronous reset in the middle of XFER
    nRST = 1'b0;
    #1 check("t7_ren", ramREN, 0);
    check("t7_wen", ramWEN, 0);
    check("t7_addr", ramaddr, 0);
    check("t7_store", ramstore, 0);
    check("t7_dwait", dwait, 2'b11);
    check("t7_iwait", iwait, 2'b11);
    check("t7_ccinv", ccinv, 0);
    check("t7_snoop0", ccsnoopaddr[0], 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
